// File: rtl/cond_copy_fifo.sv
// Packet FIFO that replicates each stored packet to a per-packet subset of
// output channels; every channel stalls independently until its copy is taken.
module cond_copy_fifo #(
    parameter int WIDTH   = 4,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_timestep,
    input  logic                         in_mask_en,
    input  logic [NUM_OUT-1:0]           in_mask,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_OUT*WIDTH-1:0]     out_data,
    output logic [NUM_OUT-1:0]           out_valid,
    input  logic [NUM_OUT-1:0]           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   drop_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        EMPTY,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       mem_data [DEPTH];
    logic [NUM_OUT-1:0]     mem_mask [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          rd_next;
    logic [NUM_OUT-1:0]     pending;
    logic [NUM_OUT-1:0]     remain;
    logic [NUM_OUT-1:0]     eff_mask;
    logic [WIDTH-1:0]       head_data;
    logic                   ready_q;
    logic                   push;
    logic                   store;
    logic                   drop;
    logic                   pop;
    logic [CW-1:0]          count_next;

    always_comb begin
        eff_mask = '0;
        if (in_mask_en)
            eff_mask = in_mask;
        else if (!in_timestep)
            eff_mask = '1;
        else
            eff_mask = NUM_OUT'(1);

        push    = in_valid && ready_q;
        store   = push && (eff_mask != '0);
        drop    = push && (eff_mask == '0);
        remain  = pending & ~out_ready;
        pop     = (state == ACTIVE) && (remain == '0);
        rd_next = rd_ptr + PW'(1);

        count_next = count;
        if (store && !pop)
            count_next = count + CW'(1);
        else if (pop && !store)
            count_next = count - CW'(1);
    end

    // The head entry is also written to memory so pointers stay in step with count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wr_ptr] <= in_data;
            mem_mask[wr_ptr] <= eff_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            pending   <= '0;
            head_data <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_q   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next < FULL);
            if (store)
                wr_ptr <= wr_ptr + PW'(1);
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                EMPTY: begin
                    if (store) begin
                        state     <= ACTIVE;
                        pending   <= eff_mask;
                        head_data <= in_data;
                    end
                end
                ACTIVE: begin
                    if (pop) begin
                        rd_ptr <= rd_next;
                        // Reload from the next entry, or straight from the input when it
                        // is being written this very edge, so no bubble is inserted.
                        if (count > CW'(1)) begin
                            pending   <= mem_mask[rd_next];
                            head_data <= mem_data[rd_next];
                        end else if (store) begin
                            pending   <= eff_mask;
                            head_data <= in_data;
                        end else begin
                            state   <= EMPTY;
                            pending <= '0;
                        end
                    end else begin
                        pending <= remain;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = pending;
    assign out_data  = {NUM_OUT{head_data}};

endmodule

// File: tb/tb_cond_copy_fifo.sv
// Directed plus random bench for cond_copy_fifo against a packet-queue reference model.
module tb_cond_copy_fifo;

    localparam int WIDTH   = 4;
    localparam int NUM_OUT = 3;
    localparam int DEPTH   = 2;
    localparam int CW      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0]   d;
        logic [NUM_OUT-1:0] m;
    } pkt_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [WIDTH-1:0]           in_data = '0;
    logic                       in_timestep = 1'b0;
    logic                       in_mask_en = 1'b0;
    logic [NUM_OUT-1:0]         in_mask = '0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [NUM_OUT*WIDTH-1:0]   out_data;
    logic [NUM_OUT-1:0]         out_valid;
    logic [NUM_OUT-1:0]         out_ready = '0;
    logic [CW-1:0]              count;
    logic [7:0]                 drop_cnt;

    int   compared   = 0;
    int   mismatched = 0;
    pkt_t q[$];
    int   m_drop  = 0;
    bit   m_ready = 0;
    bit   acc     = 0;

    cond_copy_fifo #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_timestep(in_timestep),
        .in_mask_en(in_mask_en), .in_mask(in_mask), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NUM_OUT-1:0] exp_v;
        exp_v = (q.size() > 0) ? q[0].m : '0;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("count", 32'(count), 32'(q.size()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        for (int i = 0; i < NUM_OUT; i++)
            if (exp_v[i])
                chk("out_data", 32'(out_data[i*WIDTH +: WIDTH]), 32'(q[0].d));
    endtask

    // One clock: drive at negedge, check state, advance model, let the edge happen.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic ts,
                         input logic me, input logic [NUM_OUT-1:0] mk,
                         input logic [NUM_OUT-1:0] rdy);
        logic [NUM_OUT-1:0] em;
        logic [NUM_OUT-1:0] rem;
        pkt_t h;
        @(negedge clk);
        in_valid = v; in_data = d; in_timestep = ts; in_mask_en = me;
        in_mask = mk; out_ready = rdy;
        #1;
        check_outputs();
        em  = me ? mk : (ts ? NUM_OUT'(1) : '1);
        acc = v && m_ready;
        if (q.size() > 0) begin
            h   = q[0];
            rem = h.m & ~rdy;
            if (rem == '0) void'(q.pop_front());
            else begin h.m = rem; q[0] = h; end
        end
        if (acc) begin
            if (em == '0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                q.push_back('{d: d, m: em});
            end
        end
        m_ready = (q.size() < DEPTH);
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic [NUM_OUT-1:0] rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = '0;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd0);
        chk("rel_count", 32'(count), 32'd0);
        @(posedge clk);
        m_ready = 1;
    endtask

    // Present packets in order, holding each until the model accepts it.
    task automatic push_seq(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input int n,
                            input logic [NUM_OUT-1:0] mk, input int stall);
        logic [WIDTH-1:0] ds [3];
        int k;
        int t;
        ds[0] = d0; ds[1] = d1; ds[2] = d2;
        k = 0; t = 0;
        while (k < n && t < 40) begin
            cycle(1'b1, ds[k], 1'b0, 1'b1, mk, (t < stall) ? '0 : '1);
            if (acc) k++;
            t++;
        end
        chk("push_seq_done", 32'(k), 32'(n));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // Legacy broadcast and legacy single-output routing
        cycle(1'b1, 4'hA, 1'b0, 1'b0, '0, '1);
        idle(3, '1);
        cycle(1'b1, 4'h5, 1'b1, 1'b0, '0, '1);
        idle(3, '1);

        // Channel 2 stalls while a second packet waits behind it
        cycle(1'b1, 4'h3, 1'b0, 1'b1, 3'b111, 3'b011);
        cycle(1'b1, 4'h9, 1'b0, 1'b1, 3'b111, 3'b011);
        idle(4, 3'b011);
        idle(4, '1);

        // Full FIFO blocks the third packet until the readies rise
        push_seq(4'h1, 4'h2, 4'h3, 3, 3'b111, 6);
        idle(5, '1);

        // Zero mask: every handshake completes and drop_cnt saturates
        for (int i = 0; i < 300; i++)
            cycle(1'b1, WIDTH'(i), 1'b0, 1'b1, '0, NUM_OUT'($urandom));
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Randomised mix of routing modes and ready patterns
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  NUM_OUT'($urandom), NUM_OUT'($urandom));
        idle(6, '1);

        // Reset mid-operation with one partial copy done
        push_seq(4'hC, 4'hD, 4'h0, 2, 3'b111, 40);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 3'b001);
        #2 rst = 1'b1;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_out_data", 32'(out_data), 32'd0);
        chk("mid_drop_cnt", 32'(drop_cnt), 32'd0);
        q.delete(); m_drop = 0; m_ready = 0;
        repeat (2) @(posedge clk);
        release_reset();
        idle(5, '1);

        for (int i = 0; i < 100; i++)
            cycle(($urandom % 2) != 0, WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  NUM_OUT'($urandom), NUM_OUT'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cond_copy_fifo.md
# cond_copy_fifo

Clocked, parametrised successor of the timestep-gated packet copier. It accepts packets on a valid/ready input channel and buffers them in a DEPTH-entry FIFO. Each packet is replicated to a per-packet subset of NUM_OUT output channels, chosen either by the legacy timestep rule or by an explicit destination mask. It sits between the spike/packet source and the PE fan-out, and lets slow consumers stall independently without losing copies.

## Interface
- WIDTH, 4: packet data width in bits.
- NUM_OUT, 2: number of output channels, minimum 2.
- DEPTH, 2: FIFO entries, power of 2, minimum 2.
- clk  in  1: single clock, rising edge.
- rst  in  1: reset, asynchronous and active-high.
- in_data  in  WIDTH: packet payload.
- in_timestep  in  1: legacy select. 0 sends to all outputs; 1 sends to output 0 only.
- in_mask_en  in  1: 1 selects in_mask instead of the timestep rule.
- in_mask  in  NUM_OUT: explicit destination mask, bit i = output i.
- in_valid  in  1: input packet valid.
- in_ready  out  1: input can accept a packet.
- out_data  out  NUM_OUT*WIDTH: slice i is channel i's data. All slices carry the head packet.
- out_valid  out  NUM_OUT: per-channel valid.
- out_ready  in  NUM_OUT: per-channel ready.
- count  out  $clog2(DEPTH+1): occupied FIFO entries.
- drop_cnt  out  8: number of packets dropped for an empty mask. Saturates at 255.

## Operation
- Effective mask:
  - in_mask_en=1: in_mask.
  - in_mask_en=0: all-ones if in_timestep=0; otherwise only bit 0 set.
- Push:
  - Input handshake is in_valid && in_ready.
  - A non-zero effective mask writes {in_data, mask} at the write pointer and increments count.
  - A zero effective mask still completes the handshake. The packet is not stored and drop_cnt increments, saturating at 255.
- in_ready = (count < DEPTH), derived from registers only. When full, no push is accepted, even if a pop occurs in the same cycle.
- Head state machine:
  - EMPTY: count=0; out_valid all 0.
  - ACTIVE: pending[NUM_OUT-1:0] is loaded from the head entry's mask when that entry becomes head. out_valid = pending.
- Per-channel handshake: out_valid[i] && out_ready[i] clears pending[i] at the clock edge. Channels are independent; no out_valid depends combinationally on any out_ready.
- Pop:
  - Occurs when every set pending bit is cleared, including when the last bits clear in the same cycle.
  - Pop advances the read pointer and decrements count.
  - If another entry exists, pending reloads from it on that same edge, so there is no bubble. Otherwise the block returns to EMPTY.
- Simultaneous push and pop (count < DEPTH): count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty is decided by count, not by pointer comparison.
- Copies never duplicate: each channel in the mask receives exactly one handshake per packet, in FIFO order.

## Timing
- Reset, asynchronous, while rst=1:
  - out_valid=0, in_ready=0, count=0, drop_cnt=0.
  - pending=0, pointers=0; out_data is 0.
- First cycle after rst deasserts: in_ready=1.
- Reset mid-operation flushes all stored packets and pending copies immediately. No partial copy is emitted after release.
- Latency: a packet pushed at edge t into an empty FIFO has out_valid high after edge t; it is consumable at edge t+1.
- Throughput: 1 packet/cycle when all targeted channels are ready.
- While out_valid[i]=1 and out_ready[i]=0, out_data slice i and out_valid[i] hold stable.
- out_ready asserted on a channel whose pending bit is 0 has no effect.

## Test plan
- Legacy broadcast: WIDTH=4, NUM_OUT=2. Push 0xA with timestep=0, both readies high → channels 0 and 1 each see 0xA once, one cycle after the push; count returns to 0.
- Legacy single: push 0x5 with timestep=1 → only channel 0 sees 0x5; out_valid[1] stays 0 throughout.
- Skewed stall: NUM_OUT=3, mask=3'b111, out_ready[2] held 0 for 5 cycles → channels 0 and 1 complete in cycle 1; channel 2 holds the data stable; pop happens on the cycle ready[2] rises; the next packet appears with no bubble.
- Full FIFO: DEPTH=2, all readies 0, push 3 packets → the first two are accepted, count=2, and in_ready=0 blocks the third. Raise the readies → the packets drain in order 1, 2, then the third is accepted.
- Zero mask: in_mask_en=1, in_mask=0, push 300 times → handshake accepted each cycle, nothing emitted, drop_cnt saturates at 255.
- Mid-operation reset: 2 packets queued with one partial copy done; assert rst asynchronously between edges → outputs drop to 0 immediately. After release, count=0, and no residual copy appears within 5 cycles.
